amp_gain_ctrl: RTL and testbench
================================

// Module: amp_gain_ctrl
// PURPOSE
// - Multi-channel, button-controlled digital gain stage between the signal generator / audio source and the DAC path.
// - Buttons step a gain index through a constant gain table; each channel's signed sample is multiplied by the selected gain.
// - The product is optionally saturated to the output width and delivered through a 2-stage valid pipeline.
// PARAMETERS
// - DATA_W   16  signed sample width per channel
// - CH       2   number of channels processed in lockstep
// - GAIN_W   5   unsigned gain constant width
// - STEPS    5   number of valid gain-table entries (1..8)
// - OUT_W    16  signed output width per channel
// - SAT_EN   1   1: clamp to OUT_W signed range; 0: keep the low OUT_W bits of the product
// PORTS
// - clk       in   1           system clock
// - rst_n     in   1           asynchronous active-low reset
// - btn_up    in   1           raw button, increase gain (asynchronous to clk)
// - btn_dn    in   1           raw button, decrease gain (asynchronous to clk)
// - mute      in   1           forces the output samples to 0, pipeline-aligned
// - in_valid  in   1           in_data is valid this cycle
// - in_data   in   CH*DATA_W   packed signed samples; ch0 = LSBs
// - out_valid out  1           out_data is valid this cycle
// - out_data  out  CH*OUT_W    packed signed gained samples
// - gain_idx  out  3           current gain index, for LED display
// - sat_flag  out  1           sticky: some channel clipped since reset
// BEHAVIOUR
// - Reset: all sync/edge flops 0, gain_idx=0, out_valid=0, out_data=0, sat_flag=0, pipeline valid bits 0.
// - Buttons: 2-FF synchroniser, then a rising-edge detector.
//   - One step per press, never per held cycle.
//   - Press-to-gain_idx latency: 3 clk.
// - Index update:
//   - up edge: idx+1, saturating at STEPS-1 (no wrap).
//   - dn edge: idx-1, saturating at 0.
//   - Simultaneous up and dn edges: no change.
// - Gain table (package): idx 0..4 -> 1,2,4,6,8.
//   - Any idx>=STEPS is unreachable; if it ever occurs, treat it as gain 1.
// - Pipeline, no backpressure:
//   - S1 (on in_valid): register samples, GAIN_TABLE[gain_idx] and mute.
//   - S2: signed multiply by {1'b0,gain}; product width DATA_W+GAIN_W+1; saturate or truncate; register.
// - out_valid = in_valid delayed 2 clk. out_data holds its value while out_valid=0.
// - Gain is sampled per accepted sample at S1, so a gain change never splits a sample across channels.
// - Saturation (SAT_EN=1):
//   - product > 2^(OUT_W-1)-1 -> max; product < -2^(OUT_W-1) -> min.
//   - Either case sets sat_flag, which is cleared only by reset.
// - SAT_EN=0: truncate; sat_flag is held at 0.
// - mute captured with the sample at S1; a muted sample outputs 0 with out_valid still asserted.
// - Back-to-back in_valid every cycle: full throughput, 1 sample/clk.
// - Reset mid-operation: pipeline flushed, no stale out_valid after release.
// STRUCTURE
// - Package amp_pkg:
//   - GAIN_TABLE constant array, STEPS_MAX=8.
//   - Function sat_signed(value, width).
//   - Typedef gain_idx_t (logic [2:0]).
// - Sub-module btn_edge_sync (2-FF sync + rising-edge pulse), instanced twice.
// - Per-channel multiply/saturate in a generate loop. The multiplier is inferred; no separate booth instance.
// TESTING
// - Reset, then in_data ch0=0x0100, ch1=-0x0100, in_valid 1 clk -> 2 clk later out_valid=1, out 0x0100/-0x0100 (gain 1).
// - 4 up presses, 1 clk pulses spaced 10 clk, then ch0=0x0100 -> gain_idx 0,1,2,3,4 -> out 0x0800 (x8).
// - 2 more up presses -> gain_idx stays 4; then 6 dn presses -> gain_idx stays 0 (no wrap).
// - btn_up held 100 clk -> exactly one step. btn_up and btn_dn edges in the same clk -> no change.
// - gain 8, ch0=0x1000, ch1=-0x1000, SAT_EN=1 -> 0x7FFF / -0x8000, sat_flag=1 (sticky).
//   - SAT_EN=0 -> 0x8000 / 0x8000, sat_flag=0.
// - in_valid every clk for 64 samples, mute asserted on sample 10 only, rst_n pulsed at sample 40:
//   - out_valid continuous before the reset; only sample 10 outputs 0.
//   - Immediately after the reset: out_valid=0, gain_idx=0, sat_flag=0.

Source files
------------

// File: rtl/amp_gain_ctrl_pkg.sv
// Shared gain table, index type and saturation helper for the amplifier gain stage.
package amp_pkg;

   localparam int STEPS_MAX = 8;
   localparam int TBL_W     = 5;

   typedef logic [2:0] gain_idx_t;

   // Entry 0 is the LSB group. Entries past the populated steps are unity gain.
   localparam logic [STEPS_MAX-1:0][TBL_W-1:0] GAIN_TABLE = {
      5'd1, 5'd1, 5'd1, 5'd8, 5'd6, 5'd4, 5'd2, 5'd1
   };

   // Table lookup. An index at or beyond the configured step count falls back to gain 1.
   function automatic logic [TBL_W-1:0] gain_lookup(input gain_idx_t idx, input int steps);
      logic [TBL_W-1:0] g;
      g = 5'd1;
      if (int'(idx) < steps) g = GAIN_TABLE[idx];
      return g;
   endfunction

   // Clamp a signed value into the two's-complement range of the given width.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] res;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      res   = value;
      if (value > max_v)      res = max_v;
      else if (value < min_v) res = min_v;
      return res;
   endfunction

endpackage

// File: rtl/amp_gain_ctrl_btn_edge_sync.sv
// Brings a raw, asynchronous button into the clock domain and emits one pulse per press.
module btn_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Two-flop synchroniser followed by a one-cycle history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // A held button only produces a pulse on its first synchronised cycle.
   assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/amp_gain_ctrl.sv
// Button-stepped multi-channel gain stage: gain index control, two-stage sample pipeline,
// per-channel multiply with optional saturation and a sticky clip flag.
module amp_gain_ctrl
   import amp_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CH     = 2,
   parameter int GAIN_W = 5,
   parameter int STEPS  = 5,
   parameter int OUT_W  = 16,
   parameter int SAT_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn_up,
   input  logic                  btn_dn,
   input  logic                  mute,
   input  logic                  in_valid,
   input  logic [CH*DATA_W-1:0]  in_data,
   output logic                  out_valid,
   output logic [CH*OUT_W-1:0]   out_data,
   output logic [2:0]            gain_idx,
   output logic                  sat_flag
);

   localparam int        PROD_W  = DATA_W + GAIN_W + 1;
   localparam gain_idx_t IDX_MAX = gain_idx_t'(STEPS - 1);

   logic                 up_pulse;
   logic                 dn_pulse;
   gain_idx_t            idx_q;
   gain_idx_t            idx_d;

   logic                 v1_q;
   logic [CH*DATA_W-1:0] smp_q;
   logic [GAIN_W-1:0]    gain_q;
   logic                 mute_q;

   logic [CH*OUT_W-1:0]  res_d;
   logic [CH-1:0]        clip_d;

   logic                 v2_q;
   logic [CH*OUT_W-1:0]  out_q;
   logic                 sat_q;

   btn_edge_sync u_sync_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_up),
      .pulse_o (up_pulse)
   );

   btn_edge_sync u_sync_dn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_dn),
      .pulse_o (dn_pulse)
   );

   // Saturating index step; opposing presses in the same cycle cancel.
   always_comb begin
      idx_d = idx_q;
      if (up_pulse && !dn_pulse && (idx_q < IDX_MAX)) begin
         idx_d = idx_q + 3'd1;
      end else if (dn_pulse && !up_pulse && (idx_q != 3'd0)) begin
         idx_d = idx_q - 3'd1;
      end
   end

   // Gain index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end

   // Stage 1: capture samples together with the gain and mute in force for them, so a
   // gain change never lands between the channels of one sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         smp_q  <= '0;
         gain_q <= '0;
         mute_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            smp_q  <= in_data;
            gain_q <= GAIN_W'(gain_lookup(idx_q, STEPS));
            mute_q <= mute;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DATA_W-1:0] smp;
      logic signed [PROD_W-1:0] prod;

      assign smp  = $signed(smp_q[c*DATA_W +: DATA_W]);
      // Gain is unsigned; the zero MSB keeps it positive in the signed multiply.
      assign prod = PROD_W'(smp) * PROD_W'($signed({1'b0, gain_q}));

      if (SAT_EN != 0) begin : g_sat
         logic signed [63:0] prod_ext;
         logic signed [63:0] sat_v;
         assign prod_ext = 64'(prod);
         assign sat_v    = sat_signed(prod_ext, OUT_W);
         assign res_d[c*OUT_W +: OUT_W] = sat_v[OUT_W-1:0];
         assign clip_d[c]               = (sat_v != prod_ext);
      end else begin : g_trunc
         assign res_d[c*OUT_W +: OUT_W] = OUT_W'(prod);
         assign clip_d[c]               = 1'b0;
      end
   end

   // Stage 2: register the gained result; out_data holds between valid samples. A muted
   // sample never reaches the output, so it cannot raise the clip flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q  <= 1'b0;
         out_q <= '0;
         sat_q <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            out_q <= mute_q ? '0 : res_d;
            if (!mute_q && (|clip_d)) sat_q <= 1'b1;
         end
      end
   end

   assign out_valid = v2_q;
   assign out_data  = out_q;
   assign gain_idx  = idx_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_amp_gain_ctrl.sv
// Bench for amp_gain_ctrl: a saturating and a truncating instance share all stimulus;
// expected samples go into a scoreboard queue at drive time and are popped on out_valid.
`timescale 1ns/1ps
module tb_amp_gain_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_dn = 1'b0;
   logic        mute = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;

   logic        out_valid_s, out_valid_t;
   logic [31:0] out_data_s, out_data_t;
   logic [2:0]  gi_s, gi_t;
   logic        sat_flag_s, sat_flag_t;

   int checks = 0;
   int failures = 0;
   int exp_idx = 0;
   int gains[5];

   typedef struct {
      logic [31:0] s;
      logic [31:0] t;
   } exp_t;

   typedef struct {
      logic [15:0] a0;
      logic [15:0] a1;
      logic        m;
      logic [15:0] s0;
      logic [15:0] s1;
      logic [15:0] t0;
      logic [15:0] t1;
   } vec_t;

   exp_t sb_q[$];
   vec_t vg1[4];
   vec_t vg8[4];

   always #5 clk = ~clk;

   amp_gain_ctrl #(.SAT_EN(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .mute(mute),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid_s),
      .out_data(out_data_s), .gain_idx(gi_s), .sat_flag(sat_flag_s)
   );

   amp_gain_ctrl #(.SAT_EN(0)) dut_t (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .mute(mute),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid_t),
      .out_data(out_data_t), .gain_idx(gi_t), .sat_flag(sat_flag_t)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer, sampled on the falling edge.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid_s) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected no output at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            check("out_sat", out_data_s, e.s);
            check("out_trunc", out_data_t, e.t);
            check("valid_trunc", 32'(out_valid_t), 32'd1);
         end
      end
   end

   task automatic send(input logic [15:0] a0, input logic [15:0] a1, input logic m,
                       input logic [15:0] s0, input logic [15:0] s1,
                       input logic [15:0] t0, input logic [15:0] t1);
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = {a1, a0};
      mute     = m;
      e.s = {s1, s0};
      e.t = {t1, t0};
      sb_q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      mute     = 1'b0;
   endtask

   // One-cycle button pulse; checks the index is unchanged 2 clk after and updated 3 clk after.
   task automatic press(input logic up, input logic dn, input string name);
      int nxt;
      nxt = exp_idx;
      if (up && !dn && exp_idx < 4)      nxt = exp_idx + 1;
      else if (dn && !up && exp_idx > 0) nxt = exp_idx - 1;
      @(posedge clk); #1;
      btn_up = up;
      btn_dn = dn;
      @(posedge clk); #1;
      btn_up = 1'b0;
      btn_dn = 1'b0;
      @(posedge clk); #1;
      check({name, "_idx_lat2"}, 32'(gi_s), 32'(exp_idx));
      @(posedge clk); #1;
      check({name, "_idx_lat3"}, 32'(gi_s), 32'(nxt));
      exp_idx = nxt;
      repeat (8) @(posedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v;
      logic [15:0] x;

      gains = '{1, 2, 4, 6, 8};
      vg1[0] = '{16'h0100, 16'hFF00, 1'b0, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
      vg1[1] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      vg1[2] = '{16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vg1[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
      vg8[0] = '{16'h1000, 16'hF000, 1'b0, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
      vg8[1] = '{16'h0FFF, 16'hF001, 1'b0, 16'h7FF8, 16'h8008, 16'h7FF8, 16'h8008};
      vg8[2] = '{16'h7FFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vg8[3] = '{16'hFFFF, 16'h2000, 1'b0, 16'hFFF8, 16'h7FFF, 16'hFFF8, 16'h0000};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid_s), 32'd0);
      check("rst_out_data", out_data_s, 32'd0);
      check("rst_gain_idx", 32'(gi_s), 32'd0);
      check("rst_sat_flag", 32'(sat_flag_s), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // First sample: 2-clk latency at unity gain.
      send(16'h0100, 16'hFF00, 1'b0, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_after_1clk", 32'(out_valid_s), 32'd0);
      @(posedge clk); #1;
      check("lat_after_2clk", 32'(out_valid_s), 32'd1);
      repeat (3) @(posedge clk);

      // Unity-gain vectors back to back, then hold check.
      for (int i = 0; i < 4; i++)
         send(vg1[i].a0, vg1[i].a1, vg1[i].m, vg1[i].s0, vg1[i].s1, vg1[i].t0, vg1[i].t1);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("hold_out_data", out_data_s, {vg1[3].s1, vg1[3].s0});
      check("sat_flag_g1", 32'(sat_flag_s), 32'd0);

      // Step through every gain and measure it.
      for (int k = 1; k <= 4; k++) begin
         press(1'b1, 1'b0, "up");
         v = 256 * gains[exp_idx];
         send(16'h0100, 16'h0000, 1'b0, 16'(v), 16'h0000, 16'(v), 16'h0000);
         idle();
         repeat (3) @(posedge clk);
      end
      #1;
      check("sat_flag_no_clip_g8", 32'(sat_flag_s), 32'd0);
      press(1'b1, 1'b0, "up_top");
      press(1'b1, 1'b0, "up_top");

      // Gain 8 vectors: clipping vs truncation.
      for (int i = 0; i < 4; i++)
         send(vg8[i].a0, vg8[i].a1, vg8[i].m, vg8[i].s0, vg8[i].s1, vg8[i].t0, vg8[i].t1);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("sat_flag_set", 32'(sat_flag_s), 32'd1);
      check("sat_flag_trunc", 32'(sat_flag_t), 32'd0);

      for (int k = 0; k < 6; k++) press(1'b0, 1'b1, "dn");
      send(16'h0100, 16'h0010, 1'b0, 16'h0100, 16'h0010, 16'h0100, 16'h0010);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("sat_flag_sticky", 32'(sat_flag_s), 32'd1);

      // Held button: one step only.
      @(posedge clk); #1;
      btn_up = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("held_idx", 32'(gi_s), 32'd1);
      btn_up = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("held_release_idx", 32'(gi_s), 32'd1);
      exp_idx = 1;

      press(1'b1, 1'b1, "both");

      // Streaming with mute on sample 10 and a reset at sample 40.
      for (int i = 0; i < 64; i++) begin
         x = 16'(i * 16 + 1);
         @(posedge clk); #1;
         if (i == 40) begin
            rst_n    = 1'b0;
            in_valid = 1'b1;
            in_data  = {-x, x};
            mute     = 1'b0;
            sb_q.delete();
            exp_idx  = 0;
            #1;
            check("stream_rst_out_valid", 32'(out_valid_s), 32'd0);
            check("stream_rst_gain_idx", 32'(gi_s), 32'd0);
            check("stream_rst_sat_flag", 32'(sat_flag_s), 32'd0);
         end else begin
            if (i == 41) rst_n = 1'b1;
            if (i < 40 && i >= 2) check("stream_valid_cont", 32'(out_valid_s), 32'd1);
            if (i == 41 || i == 42) check("stream_no_stale_valid", 32'(out_valid_s), 32'd0);
            in_valid = 1'b1;
            in_data  = {-x, x};
            mute     = (i == 10);
            v = (i * 16 + 1) * ((i < 40) ? 2 : 1);
            if (i == 10) begin
               sb_q.push_back('{s: 32'd0, t: 32'd0});
            end else begin
               sb_q.push_back('{s: {16'(-v), 16'(v)}, t: {16'(-v), 16'(v)}});
            end
         end
      end
      idle();
      repeat (6) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
